execute_stage: RTL
==================

// Module: execute_stage
// PURPOSE
//  Y86-64 pipeline Execute stage; consumes E_* register written by the decode stage, drives the M register.
//  Computes ALU result valE, owns the condition-code register (ZF/SF/OF), evaluates jXX/cmovXX condition.
//  Exports e_valE/e_dstE combinationally for decode-stage forwarding.
// PARAMETERS
//  DW        64      datapath width (valA/valB/valC/valE)
//  STAT_AOK  3'b001  status encoding for normal operation / bubble
// PORTS
//  clk       in   1   rising-edge clock
//  rst_n     in   1   asynchronous reset, active-low
//  E_stat    in   3   status of instruction in E
//  E_icode   in   4   instruction code
//  E_ifun    in   4   function code (ALU op or condition)
//  E_valC    in   DW  constant
//  E_valA    in   DW  operand A (forwarded)
//  E_valB    in   DW  operand B (forwarded)
//  E_dstE    in   4   ALU dest reg, 4'hF = none
//  E_dstM    in   4   memory dest reg, 4'hF = none
//  cc_block  in   1   from pipeline control: 1 = inhibit CC write (exception in M/W)
//  M_bubble  in   1   load bubble into M register this edge
//  e_valE    out  DW  combinational ALU result (forwarding)
//  e_dstE    out  4   combinational effective dstE (forwarding)
//  e_Cnd     out  1   combinational condition result
//  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM   out  3/4/1/DW/DW/4/4  M pipeline register
//  cc_zf, cc_sf, cc_of   out  1 each  current CC register
// BEHAVIOUR
//  Reset (rst_n=0, async): CC = {ZF=1,SF=0,OF=0}; M reg = bubble: stat=STAT_AOK, icode=4'h1, Cnd=0,
//   valE=valA=0, dstE=dstM=4'hF. Reset dominates M_bubble and normal load.
//  aluA: icode 2,6 -> valA; 3,4,5 -> valC; 8,A -> -8; 9,B -> +8; else 0.
//  aluB: icode 4,5,6,8,9,A,B -> valB; 2,3 -> 0; else 0.
//  alufun: icode 6 uses ifun (0 add, 1 sub = aluB-aluA, 2 and, 3 xor; ifun>3 -> valE=0); others add.
//  All arithmetic modulo 2^DW, two's complement, no saturation.
//  OF: add -> sign(A)==sign(B) && sign(R)!=sign(A); sub -> sign(B)!=sign(A) && sign(R)!=sign(B); and/xor -> 0.
//  CC write at posedge iff icode==6 && E_stat==STAT_AOK && !cc_block; ZF=(R==0), SF=R[DW-1].
//  e_Cnd from current (pre-update) CC: ifun 0 always,1 le (SF^OF)|ZF,2 l SF^OF,3 e ZF,4 ne !ZF,
//   5 ge !(SF^OF),6 g !(SF^OF)&!ZF, 7-F -> 0. Meaningful for icode 2,7; M_Cnd carries it.
//  e_dstE = (icode==2 && !e_Cnd) ? 4'hF : E_dstE.
//  Latency 1: E values at edge N appear on M_* after edge N; OPq CC visible to instruction behind it.
//  M_bubble=1 at edge: M reg loads bubble values (same as reset); CC write still governed by rules above.
//  M_valA = E_valA, M_stat/icode/dstM pass through unmodified; M_dstE = e_dstE.
//  Non-AOK E_stat: ALU still computes; no CC update; status propagated to M.
// CONFIGURATION
//  EXEC_STATS_EN defined: adds outputs stat_alu_cnt[31:0] (+1 per CC-writing OPq) and
//   stat_bubble_cnt[31:0] (+1 per edge with M_bubble=1); both reset to 0, wrap at 2^32.
//  Undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
//  Reset mid-run with rst_n low between edges -> M_icode=1, M_dstE=F, ZF=1 immediately (async).
//  OPq add valA=1,valB=7FFF..FF -> e_valE=8000..00, after edge SF=1 OF=1 ZF=0.
//  OPq sub valA=5,valB=5 then cmovE (ifun 3) dstE=2 -> cmov sees ZF=1, e_dstE=2; cmovNE -> e_dstE=F.
//  OPq with cc_block=1 or E_stat=3'b010 -> CC unchanged, M_stat carries E_stat.
//  pushq valB=1024 -> e_valE=1016; popq valB=1016 -> e_valE=1024; irmovq valC=42 -> e_valE=42.
//  M_bubble=1 with valid OPq in E -> M becomes bubble, CC still updated; e_valE still driven.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage that computes valE, holds the ZF/SF/OF condition codes, evaluates jXX/cmovXX and drives the M register
// Ports: clk, rst_n (async, active-low); E_* decode-stage register inputs; cc_block inhibits CC writes; M_bubble loads a bubble into M.
//        e_valE/e_dstE/e_Cnd are combinational for forwarding; M_* is the M register; cc_zf/cc_sf/cc_of expose the CC register.
// Option: EXEC_STATS_EN adds stat_alu_cnt (CC-writing OPq count) and stat_bubble_cnt (M_bubble edge count).
module execute_stage #(
  parameter int DW = 64,
  parameter logic [2:0] STAT_AOK = 3'b001
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    E_stat,
  input  logic [3:0]    E_icode,
  input  logic [3:0]    E_ifun,
  input  logic [DW-1:0] E_valC,
  input  logic [DW-1:0] E_valA,
  input  logic [DW-1:0] E_valB,
  input  logic [3:0]    E_dstE,
  input  logic [3:0]    E_dstM,
  input  logic          cc_block,
  input  logic          M_bubble,
  output logic [DW-1:0] e_valE,
  output logic [3:0]    e_dstE,
  output logic          e_Cnd,
  output logic [2:0]    M_stat,
  output logic [3:0]    M_icode,
  output logic          M_Cnd,
  output logic [DW-1:0] M_valE,
  output logic [DW-1:0] M_valA,
  output logic [3:0]    M_dstE,
  output logic [3:0]    M_dstM,
  output logic          cc_zf,
  output logic          cc_sf,
  output logic          cc_of
`ifdef EXEC_STATS_EN
  ,
  output logic [31:0]   stat_alu_cnt,
  output logic [31:0]   stat_bubble_cnt
`endif
);
  localparam logic [DW-1:0] EIGHT = DW'(8);
  logic [DW-1:0] alu_a, alu_b, sum, diff;
  logic [3:0] fn;
  logic alu_of, lt, cc_we;
  always_comb begin
    alu_a = (E_icode == 4'h2 || E_icode == 4'h6) ? E_valA :
            (E_icode inside {4'h3, 4'h4, 4'h5}) ? E_valC :
            (E_icode == 4'h8 || E_icode == 4'hA) ? -EIGHT :
            (E_icode == 4'h9 || E_icode == 4'hB) ? EIGHT : '0;
    alu_b = (E_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? E_valB : '0;
    fn = (E_icode == 4'h6) ? E_ifun : 4'h0;
    sum = alu_b + alu_a;
    diff = alu_b - alu_a;
    e_valE = fn == 4'h0 ? sum : fn == 4'h1 ? diff : fn == 4'h2 ? (alu_a & alu_b) :
             fn == 4'h3 ? (alu_a ^ alu_b) : '0;
    alu_of = fn == 4'h0 ? (alu_a[DW-1] == alu_b[DW-1] && sum[DW-1] != alu_a[DW-1]) :
             fn == 4'h1 ? (alu_b[DW-1] != alu_a[DW-1] && diff[DW-1] != alu_b[DW-1]) : 1'b0;
    lt = cc_sf ^ cc_of;
    e_Cnd = E_ifun == 4'h0 ? 1'b1 : E_ifun == 4'h1 ? (lt | cc_zf) : E_ifun == 4'h2 ? lt :
            E_ifun == 4'h3 ? cc_zf : E_ifun == 4'h4 ? !cc_zf : E_ifun == 4'h5 ? !lt :
            E_ifun == 4'h6 ? (!lt && !cc_zf) : 1'b0;
    e_dstE = (E_icode == 4'h2 && !e_Cnd) ? 4'hF : E_dstE;
    cc_we = E_icode == 4'h6 && E_stat == STAT_AOK && !cc_block;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {cc_zf, cc_sf, cc_of} <= 3'b100;
    else if (cc_we) {cc_zf, cc_sf, cc_of} <= {e_valE == '0, e_valE[DW-1], alu_of};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || M_bubble) begin
      M_stat <= STAT_AOK;
      M_icode <= 4'h1;
      M_Cnd <= 1'b0;
      M_valE <= '0;
      M_valA <= '0;
      M_dstE <= 4'hF;
      M_dstM <= 4'hF;
    end else begin
      M_stat <= E_stat;
      M_icode <= E_icode;
      M_Cnd <= e_Cnd;
      M_valE <= e_valE;
      M_valA <= E_valA;
      M_dstE <= e_dstE;
      M_dstM <= E_dstM;
    end
  end
`ifdef EXEC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_alu_cnt <= '0;
      stat_bubble_cnt <= '0;
    end else begin
      stat_alu_cnt <= stat_alu_cnt + 32'(cc_we);
      stat_bubble_cnt <= stat_bubble_cnt + 32'(M_bubble);
    end
  end
`endif
endmodule
